// File: rtl/pio_reg_responder.sv
// pio_reg_responder
//   Fabric-side responder for the Nios PIO register bus. Software toggles
//   level strobes (addr_write, swrite, sread, cread). Each rising edge
//   performs one byte-wide register action. Masked changes on the fabric
//   event lines are timestamped into a FIFO that software drains byte-wise.
//
// Ports
//   clk         in   1     system clock
//   reset       in   1     asynchronous active-high reset
//   addr        in   8     register address, latched on addr_write rise
//   addr_write  in   1     address latch strobe
//   wdata       in   8     write data
//   swrite      in   1     write strobe: reg[addr_lat] <= wdata
//   sread       in   1     read strobe: rdata <= reg[addr_lat]
//   cread       in   1     pop strobe for the event FIFO head
//   rdata       out  8     read data back to the PIO
//   ev_in       in   EV_W  fabric event lines
//   time_out    out  32    free-running timestamp
//   signals_out out  32    {fifo_count, status, ctrl, mask}, registered
module pio_reg_responder #(
  parameter int FIFO_AW = 4,
  parameter int EV_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      addr,
  input  logic            addr_write,
  input  logic [7:0]      wdata,
  input  logic            swrite,
  input  logic            sread,
  input  logic            cread,
  output logic [7:0]      rdata,
  input  logic [EV_W-1:0] ev_in,
  output logic [31:0]     time_out,
  output logic [31:0]     signals_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 32 + EV_W;

  logic              aw_q, sw_q, sr_q, cr_q;
  logic              aw_rise, sw_rise, sr_rise, cr_rise;
  logic [7:0]        addr_lat, eff_addr;
  logic              capture_en;
  logic [7:0]        mask, scratch;
  logic              overflow;
  logic [EV_W-1:0]   ev_prev;
  logic [EW-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]  count;

  logic              empty, full, event_hit, push, pop, flush, ts_clr, ovf_set, ovf_clr;
  logic [EW-1:0]     head;
  logic [31:0]       head_ts, head_ev;
  logic [7:0]        status_byte, ctrl_byte, rd_val;

  assign aw_rise = addr_write & ~aw_q;
  assign sw_rise = swrite & ~sw_q;
  assign sr_rise = sread & ~sr_q;
  assign cr_rise = cread & ~cr_q;

  // Decode: a same-cycle addr_write makes the new address visible to
  // swrite/sread immediately. A flush cancels any same-cycle push or pop;
  // a push into a full FIFO only survives if a pop frees a slot.
  always_comb begin
    eff_addr    = aw_rise ? addr : addr_lat;
    ts_clr      = sw_rise && (eff_addr == 8'h00) && wdata[1];
    flush       = sw_rise && (eff_addr == 8'h00) && wdata[2];
    ovf_clr     = sw_rise && (eff_addr == 8'h11) && wdata[2];
    empty       = (count == '0);
    full        = (count == (FIFO_AW+1)'(DEPTH));
    event_hit   = capture_en && (|((ev_in ^ ev_prev) & EV_W'(mask)));
    pop         = cr_rise && !empty && !flush;
    push        = event_hit && !flush && (!full || pop);
    ovf_set     = event_hit && !flush && full && !pop;
    head        = mem[rd_ptr];
    head_ts     = head[EW-1:EV_W];
    head_ev     = 32'(head[EV_W-1:0]);
    status_byte = {5'b0, overflow, full, empty};
    ctrl_byte   = {7'b0, capture_en};
  end

  // Read mux sampled at the sread edge, so it sees the pre-pop head.
  always_comb begin
    rd_val = 8'h00;
    case (eff_addr)
      8'h00: rd_val = ctrl_byte;
      8'h01: rd_val = mask;
      8'h02: rd_val = scratch;
      8'h10: rd_val = 8'(count);
      8'h11: rd_val = status_byte;
      8'h20, 8'h21, 8'h22, 8'h23:
        rd_val = empty ? 8'h00 : head_ts[{eff_addr[1:0], 3'b000} +: 8];
      8'h24, 8'h25, 8'h26, 8'h27:
        rd_val = empty ? 8'h00 : head_ev[{eff_addr[1:0], 3'b000} +: 8];
      default: rd_val = 8'h00;
    endcase
  end

  // Strobe history, address latch, control registers and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_q       <= 1'b0;
      sw_q       <= 1'b0;
      sr_q       <= 1'b0;
      cr_q       <= 1'b0;
      addr_lat   <= 8'h00;
      capture_en <= 1'b0;
      mask       <= 8'h00;
      scratch    <= 8'h00;
      rdata      <= 8'h00;
    end else begin
      aw_q     <= addr_write;
      sw_q     <= swrite;
      sr_q     <= sread;
      cr_q     <= cread;
      addr_lat <= eff_addr;
      if (sw_rise) begin
        case (eff_addr)
          8'h00:   capture_en <= wdata[0];
          8'h01:   mask       <= wdata;
          8'h02:   scratch    <= wdata;
          default: ;
        endcase
      end
      if (sr_rise) rdata <= rd_val;
    end
  end

  // Timestamp counter, event history and registered status word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_out    <= 32'h0;
      ev_prev     <= '0;
      signals_out <= 32'h0;
    end else begin
      time_out    <= ts_clr ? 32'h0 : time_out + 32'd1;
      ev_prev     <= ev_in;
      signals_out <= {8'(count), status_byte, ctrl_byte, mask};
    end
  end

  // FIFO bookkeeping. Overflow set takes precedence over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Event storage needs no reset; entries are only read when counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {time_out, ev_in};
  end

endmodule

// File: tb/tb_pio_reg_responder.sv
// tb_pio_reg_responder
//   Directed-plus-random bench for pio_reg_responder. A transaction-level
//   model (queue FIFO, plain register variables) predicts rdata, time_out
//   and signals_out for every clock step.
module tb_pio_reg_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr, wdata;
  logic        addr_write, swrite, sread, cread;
  logic [7:0]  ev_in;
  logic [7:0]  rdata;
  logic [31:0] time_out, signals_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_time;
  logic        m_en, m_ovf;
  logic [7:0]  m_mask, m_scratch, m_addr, m_rdata, m_evp;
  logic [31:0] m_sig;
  logic [39:0] m_q[$];
  logic        p_aw, p_sw, p_sr, p_cr;

  pio_reg_responder #(.FIFO_AW(4), .EV_W(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .addr_write(addr_write),
    .wdata(wdata), .swrite(swrite), .sread(sread), .cread(cread),
    .rdata(rdata), .ev_in(ev_in), .time_out(time_out), .signals_out(signals_out)
  );

  always #5 clk = ~clk;

  // Register view as software sees it.
  function automatic logic [7:0] mread(input logic [7:0] a);
    logic [39:0] e;
    logic [31:0] ts, ev;
    mread = 8'h00;
    if (a == 8'h00) mread = {7'b0, m_en};
    else if (a == 8'h01) mread = m_mask;
    else if (a == 8'h02) mread = m_scratch;
    else if (a == 8'h10) mread = 8'(m_q.size());
    else if (a == 8'h11) mread = {5'b0, m_ovf, m_q.size() == 16, m_q.size() == 0};
    else if (a >= 8'h20 && a <= 8'h27 && m_q.size() > 0) begin
      e  = m_q[0];
      ts = e[39:8];
      ev = {24'h0, e[7:0]};
      if (a < 8'h24) mread = 8'((ts >> (8 * (a - 8'h20))) & 32'hFF);
      else           mread = 8'((ev >> (8 * (a - 8'h24))) & 32'hFF);
    end
  endfunction

  task automatic model_reset();
    m_time = 0; m_en = 0; m_ovf = 0; m_mask = 0; m_scratch = 0;
    m_addr = 0; m_rdata = 0; m_evp = 0; m_sig = 0;
    m_q.delete();
    p_aw = 0; p_sw = 0; p_sr = 0; p_cr = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // step the DUT by the same clock edge.
  task automatic applyStimulus();
    logic awr, swr, srr, crr, push, pop;
    logic [7:0] a;
    int n;
    awr = addr_write & ~p_aw;
    swr = swrite & ~p_sw;
    srr = sread & ~p_sr;
    crr = cread & ~p_cr;
    a   = awr ? addr : m_addr;
    n   = m_q.size();
    m_sig = {8'(n), {5'b0, m_ovf, n == 16, n == 0}, {7'b0, m_en}, m_mask};
    push = m_en && (((ev_in ^ m_evp) & m_mask) != 8'h00);
    pop  = crr && (n > 0);
    if (srr) m_rdata = mread(a);
    if (swr && a == 8'h11 && wdata[2]) m_ovf = 0;
    if (swr && a == 8'h00 && wdata[2]) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (n < 16 || pop) m_q.push_back({m_time, ev_in});
        else m_ovf = 1;
      end
    end
    if (swr) begin
      if (a == 8'h00) m_en = wdata[0];
      else if (a == 8'h01) m_mask = wdata;
      else if (a == 8'h02) m_scratch = wdata;
    end
    m_time = (swr && a == 8'h00 && wdata[1]) ? 32'h0 : m_time + 32'd1;
    m_evp  = ev_in;
    m_addr = a;
    p_aw = addr_write; p_sw = swrite; p_sr = sread; p_cr = cread;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    addr = a; addr_write = 1; applyStimulus();
    addr_write = 0; wdata = d; swrite = 1; applyStimulus();
    swrite = 0; applyStimulus();
  endtask

  task automatic read_reg(input logic [7:0] a, input string tag);
    addr = a; addr_write = 1; applyStimulus();
    addr_write = 0; sread = 1; applyStimulus();
    checkOutput(tag, {24'h0, rdata}, {24'h0, m_rdata});
    checkOutput({tag, "_sig"}, signals_out, m_sig);
    sread = 0; applyStimulus();
  endtask

  task automatic pop_head();
    cread = 1; applyStimulus();
    cread = 0; applyStimulus();
  endtask

  task automatic do_reset(input string tag);
    addr_write = 0; swrite = 0; sread = 0; cread = 0; ev_in = 0;
    reset = 1;
    #1;
    checkOutput({tag, "_rdata"}, {24'h0, rdata}, 32'h0);
    checkOutput({tag, "_time"}, time_out, 32'h0);
    checkOutput({tag, "_sig"}, signals_out, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  initial begin
    int guard;
    reset = 1; addr = 0; wdata = 0; addr_write = 0; swrite = 0;
    sread = 0; cread = 0; ev_in = 0;
    model_reset();
    $display("[TB] start");
    do_reset("rst0");
    read_reg(8'h11, "status_after_reset");

    // Held swrite performs one write; later wdata changes are ignored.
    addr = 8'h02; addr_write = 1; applyStimulus();
    addr_write = 0; wdata = 8'hA5; swrite = 1; applyStimulus();
    for (int i = 0; i < 9; i++) begin
      wdata = 8'($urandom);
      applyStimulus();
    end
    swrite = 0; applyStimulus();
    read_reg(8'h02, "scratch_held");
    write_reg(8'h02, 8'($urandom));
    read_reg(8'h02, "scratch_rand");

    // Timestamped capture at time 0x1234.
    write_reg(8'h01, 8'h01);
    write_reg(8'h00, 8'h01);
    read_reg(8'h00, "ctrl_en");
    guard = 0;
    while (m_time != 32'h1234 && guard < 20000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 20000) begin
      checks++; fails++;
      $error("[TB] FAIL wait_time: observed=%h expected=%h", m_time, 32'h1234);
    end
    checkOutput("time_1234", time_out, m_time);
    ev_in = 8'h03; applyStimulus();
    read_reg(8'h10, "count_one");
    for (int a = 8'h20; a <= 8'h27; a++) read_reg(8'(a), "head_byte");
    pop_head();
    read_reg(8'h10, "count_after_pop");

    // Fill past full: 16 kept, overflow set, then write-1-to-clear.
    for (int i = 0; i < 17; i++) begin
      ev_in = ev_in ^ 8'h01;
      applyStimulus();
    end
    read_reg(8'h10, "count_full");
    read_reg(8'h11, "status_full_ovf");
    write_reg(8'h11, 8'h04);
    read_reg(8'h11, "status_ovf_clr");

    // Push and pop together at full.
    cread = 1; ev_in = ev_in ^ 8'h01; applyStimulus();
    cread = 0; applyStimulus();
    read_reg(8'h10, "count_pushpop");
    read_reg(8'h11, "status_pushpop");

    // sread and cread together return the pre-pop head.
    addr = 8'h20; addr_write = 1; applyStimulus();
    addr_write = 0; sread = 1; cread = 1; applyStimulus();
    checkOutput("sread_cread", {24'h0, rdata}, {24'h0, m_rdata});
    sread = 0; cread = 0; applyStimulus();
    read_reg(8'h20, "head_after_pop");

    // Flush, empty head read, write to read-only COUNT.
    write_reg(8'h00, 8'h05);
    read_reg(8'h10, "count_flush");
    read_reg(8'h21, "head_empty");
    ev_in = ev_in ^ 8'h01; applyStimulus();
    write_reg(8'h10, 8'($urandom));
    read_reg(8'h10, "count_ro");

    // Timestamp clear; control self-clear bits read 0.
    write_reg(8'h00, 8'h03);
    checkOutput("time_clr", time_out, m_time);
    read_reg(8'h00, "ctrl_selfclr");
    read_reg(8'h55, "unmapped");

    // Random traffic.
    write_reg(8'h01, 8'($urandom));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) ev_in = 8'($urandom);
      cread = 1'($urandom_range(0, 1));
      addr_write = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h20, 8'h27))
                                         : 8'($urandom_range(8'h10, 8'h11));
      sread = 1'($urandom_range(0, 1));
      applyStimulus();
      if (i % 10 == 9) begin
        checkOutput("rand_rdata", {24'h0, rdata}, {24'h0, m_rdata});
        checkOutput("rand_sig", signals_out, m_sig);
        checkOutput("rand_time", time_out, m_time);
      end
    end
    addr_write = 0; sread = 0; cread = 0; applyStimulus();
    read_reg(8'h11, "rand_status");

    // Reset with three entries queued.
    write_reg(8'h01, 8'h01);
    write_reg(8'h00, 8'h05);
    for (int i = 0; i < 3; i++) begin
      ev_in = ev_in ^ 8'h01;
      applyStimulus();
    end
    read_reg(8'h10, "count_three");
    do_reset("rst_mid");
    read_reg(8'h10, "count_after_rst");
    read_reg(8'h00, "ctrl_after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
